// File: rtl/tug_pkg.sv
// Shared types and widths for the tug-of-war round controller.
// The file header for round_controller names the ROUND_CTRL_AUTO_SERVE_EN build option.
package tug_pkg;

   localparam int unsigned SCORE_W = 3;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      COUNTDOWN,
      PLAY,
      POINT,
      OVER
   } state_t;

   // Score increment that sticks at the winning score instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                  input logic [SCORE_W-1:0] lim);
      return (s >= lim) ? lim : s + 1'b1;
   endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter decremented by a tick enable; it holds at zero.
// Drives both the pre-round countdown and the post-point serve delay.
module tick_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/round_controller.sv
// Match sequencer for the tug-of-war game: countdown, play, point, match over.
// Build option ROUND_CTRL_AUTO_SERVE_EN: POINT waits SERVE_TICKS ticks instead of a start press.
module round_controller
   import tug_pkg::*;
#(
   parameter int unsigned WIN_SCORE   = 7,
   parameter int unsigned CD_TICKS    = 3,
   parameter int unsigned SERVE_TICKS = 2
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       start,
   input  logic       tick,
   input  logic       left_win,
   input  logic       right_win,
   output logic       field_clr,
   output logic       play_en,
   output logic [2:0] score_l,
   output logic [2:0] score_r,
   output logic [3:0] cd_count,
   output logic       match_over,
   output logic       winner_left
);

   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   CD_LOAD    = CNT_W'(CD_TICKS);
   localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);

   state_t             state, state_n;
   logic [SCORE_W-1:0] score_l_n, score_r_n;
   logic               over_n, winner_left_n;
   logic               field_clr_n, play_en_n;
   logic               cnt_load, cnt_dec, load_serve;
   logic [CNT_W-1:0]   cnt_load_val;
   logic               cnt_zero;
   logic               cnt_last;

   tick_down_counter #(.W(CNT_W)) u_cnt (
      .clk      (Clock),
      .rst      (Reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (cd_count),
      .zero     (cnt_zero)
   );

   assign cnt_load_val = load_serve ? SERVE_LOAD : CD_LOAD;
   assign cnt_last     = (cd_count == CNT_W'(1)) || cnt_zero;

   always_comb begin
      state_n       = state;
      score_l_n     = score_l;
      score_r_n     = score_r;
      over_n        = match_over;
      winner_left_n = winner_left;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      load_serve    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_n   = COUNTDOWN;
               score_l_n = '0;
               score_r_n = '0;
               cnt_load  = 1'b1;
            end
         end

         COUNTDOWN: begin
            if (tick) begin
               cnt_dec = 1'b1;
               if (cnt_last)
                  state_n = PLAY;
            end
         end

         PLAY: begin
            if (left_win && right_win) begin
               state_n = POINT;
            end else if (left_win) begin
               score_l_n = sat_inc(score_l, WIN);
               if (score_l_n == WIN) begin
                  state_n       = OVER;
                  over_n        = 1'b1;
                  winner_left_n = 1'b1;
               end else begin
                  state_n = POINT;
               end
            end else if (right_win) begin
               score_r_n = sat_inc(score_r, WIN);
               if (score_r_n == WIN) begin
                  state_n       = OVER;
                  over_n        = 1'b1;
                  winner_left_n = 1'b0;
               end else begin
                  state_n = POINT;
               end
            end
`ifdef ROUND_CTRL_AUTO_SERVE_EN
            if (state_n == POINT) begin
               cnt_load   = 1'b1;
               load_serve = 1'b1;
            end
`endif
         end

         POINT: begin
`ifdef ROUND_CTRL_AUTO_SERVE_EN
            if (tick) begin
               cnt_dec = 1'b1;
               if (cnt_last) begin
                  state_n  = COUNTDOWN;
                  cnt_load = 1'b1;
               end
            end
`else
            if (start) begin
               state_n  = COUNTDOWN;
               cnt_load = 1'b1;
            end
`endif
         end

         OVER: begin
            if (start) begin
               state_n       = COUNTDOWN;
               score_l_n     = '0;
               score_r_n     = '0;
               over_n        = 1'b0;
               winner_left_n = 1'b0;
               cnt_load      = 1'b1;
            end
         end

         default: state_n = IDLE;
      endcase

      // Playfield enables rise one cycle after PLAY is entered but drop on the
      // same edge that leaves PLAY, so no press can slip into a finished round.
      play_en_n   = (state == PLAY) && (state_n == PLAY);
      field_clr_n = !((state_n == OVER) || play_en_n);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         score_l     <= '0;
         score_r     <= '0;
         match_over  <= 1'b0;
         winner_left <= 1'b0;
         field_clr   <= 1'b1;
         play_en     <= 1'b0;
      end else begin
         state       <= state_n;
         score_l     <= score_l_n;
         score_r     <= score_r_n;
         match_over  <= over_n;
         winner_left <= winner_left_n;
         field_clr   <= field_clr_n;
         play_en     <= play_en_n;
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// Vector-table and sequence checks for round_controller, scoreboarded per cycle.
// Honours ROUND_CTRL_AUTO_SERVE_EN for the serve phase expectations.
module tb_round_controller;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       start = 1'b0;
   logic       tick = 1'b0;
   logic       left_win = 1'b0;
   logic       right_win = 1'b0;
   logic       field_clr, play_en, match_over, winner_left;
   logic [2:0] score_l, score_r;
   logic [3:0] cd_count;

   typedef struct packed {
      logic       fc;
      logic       pe;
      logic [2:0] sl;
      logic [2:0] sr;
      logic [3:0] cd;
      logic       mo;
      logic       wl;
   } outs_t;

   typedef struct {
      logic  rst, st, tk, lw, rw;
      outs_t e;
      string name;
   } vec_t;

`ifdef ROUND_CTRL_AUTO_SERVE_EN
   localparam logic [3:0] SERVE_CD = 4'd2;
`else
   localparam logic [3:0] SERVE_CD = 4'd0;
`endif

   outs_t       exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   vec_t        tbl[13];

   round_controller #(
      .WIN_SCORE   (7),
      .CD_TICKS    (3),
      .SERVE_TICKS (2)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .start       (start),
      .tick        (tick),
      .left_win    (left_win),
      .right_win   (right_win),
      .field_clr   (field_clr),
      .play_en     (play_en),
      .score_l     (score_l),
      .score_r     (score_r),
      .cd_count    (cd_count),
      .match_over  (match_over),
      .winner_left (winner_left)
   );

   always #5 Clock = ~Clock;

   function automatic outs_t o(input logic fc, input logic pe, input int sl, input int sr,
                               input int cd, input logic mo, input logic wl);
      outs_t r;
      r.fc = fc; r.pe = pe; r.sl = 3'(sl); r.sr = 3'(sr); r.cd = 4'(cd); r.mo = mo; r.wl = wl;
      return r;
   endfunction

   task automatic step(input logic r, input logic s, input logic t, input logic l,
                       input logic w, input outs_t e, input string name);
      outs_t got, want;
      Reset = r; start = s; tick = t; left_win = l; right_win = w;
      exp_q.push_back(e);
      @(posedge Clock);
      #1;
      Reset = 1'b0; start = 1'b0; tick = 1'b0; left_win = 1'b0; right_win = 1'b0;
      got  = '{field_clr, play_en, score_l, score_r, cd_count, match_over, winner_left};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got fc=%b pe=%b sl=%0d sr=%0d cd=%0d mo=%b wl=%b, want fc=%b pe=%b sl=%0d sr=%0d cd=%0d mo=%b wl=%b",
                  name, got.fc, got.pe, got.sl, got.sr, got.cd, got.mo, got.wl,
                  want.fc, want.pe, want.sl, want.sr, want.cd, want.mo, want.wl);
      end
   endtask

   // From POINT into COUNTDOWN with cd_count reloaded to 3.
   task automatic serve(input int sl, input int sr);
`ifdef ROUND_CTRL_AUTO_SERVE_EN
      step(0, 1, 0, 0, 0, o(1, 0, sl, sr, 2, 0, 0), "serve_start_ignored");
      step(0, 0, 1, 0, 0, o(1, 0, sl, sr, 1, 0, 0), "serve_tick1");
      step(0, 0, 1, 0, 0, o(1, 0, sl, sr, 3, 0, 0), "serve_tick2");
`else
      step(0, 0, 1, 0, 0, o(1, 0, sl, sr, 0, 0, 0), "point_tick_ignored");
      step(0, 1, 0, 0, 0, o(1, 0, sl, sr, 3, 0, 0), "point_start");
`endif
   endtask

   // From COUNTDOWN (cd_count 3) to PLAY with play_en up.
   task automatic countdown(input int sl, input int sr);
      step(0, 0, 1, 0, 0, o(1, 0, sl, sr, 2, 0, 0), "cd_tick1");
      step(0, 0, 1, 0, 0, o(1, 0, sl, sr, 1, 0, 0), "cd_tick2");
      step(0, 0, 1, 0, 0, o(1, 0, sl, sr, 0, 0, 0), "cd_tick3");
      step(0, 0, 0, 0, 0, o(0, 1, sl, sr, 0, 0, 0), "play_enable");
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0), "reset"};
      tbl[1]  = '{0, 0, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0), "idle_tick_ignored"};
      tbl[2]  = '{0, 0, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 0), "idle_win_ignored"};
      tbl[3]  = '{0, 1, 0, 0, 0, o(1, 0, 0, 0, 3, 0, 0), "start_countdown"};
      tbl[4]  = '{0, 1, 0, 0, 0, o(1, 0, 0, 0, 3, 0, 0), "cd_start_ignored"};
      tbl[5]  = '{0, 0, 1, 0, 0, o(1, 0, 0, 0, 2, 0, 0), "cd_3_to_2"};
      tbl[6]  = '{0, 0, 0, 1, 0, o(1, 0, 0, 0, 2, 0, 0), "cd_win_ignored"};
      tbl[7]  = '{0, 0, 1, 0, 0, o(1, 0, 0, 0, 1, 0, 0), "cd_2_to_1"};
      tbl[8]  = '{0, 0, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0), "cd_1_to_play"};
      tbl[9]  = '{0, 0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0), "play_en_late"};
      tbl[10] = '{0, 1, 1, 0, 0, o(0, 1, 0, 0, 0, 0, 0), "play_start_tick_ignored"};
      tbl[11] = '{0, 0, 0, 0, 1, o(1, 0, 0, 1, SERVE_CD, 0, 0), "right_point"};
      tbl[12] = '{0, 0, 0, 0, 0, o(1, 0, 0, 1, SERVE_CD, 0, 0), "point_hold"};

      for (int i = 0; i < 13; i++)
         step(tbl[i].rst, tbl[i].st, tbl[i].tk, tbl[i].lw, tbl[i].rw, tbl[i].e, tbl[i].name);

      // Simultaneous wins replay the round without scoring.
      serve(0, 1);
      countdown(0, 1);
      step(0, 0, 0, 1, 1, o(1, 0, 0, 1, SERVE_CD, 0, 0), "both_win_replay");

      // Left takes seven rounds.
      for (int k = 1; k <= 7; k++) begin
         serve(k - 1, 1);
         countdown(k - 1, 1);
         if (k < 7)
            step(0, 0, 0, 1, 0, o(1, 0, k, 1, SERVE_CD, 0, 0), "left_point");
         else
            step(0, 0, 0, 1, 0, o(0, 0, 7, 1, 0, 1, 1), "left_match");
      end
      step(0, 0, 0, 1, 0, o(0, 0, 7, 1, 0, 1, 1), "over_win_saturate");
      step(0, 0, 1, 0, 1, o(0, 0, 7, 1, 0, 1, 1), "over_tick_ignored");
      step(0, 1, 0, 0, 0, o(1, 0, 0, 0, 3, 0, 0), "over_restart");
      step(0, 0, 1, 0, 0, o(1, 0, 0, 0, 2, 0, 0), "restart_tick");

      // Reset mid-countdown beats a concurrent start.
      step(1, 1, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0), "reset_mid_countdown");
      step(0, 1, 1, 0, 0, o(1, 0, 0, 0, 3, 0, 0), "start_beats_tick");

      // Right takes seven rounds.
      countdown(0, 0);
      for (int k = 1; k <= 7; k++) begin
         if (k < 7)
            step(0, 0, 0, 0, 1, o(1, 0, 0, k, SERVE_CD, 0, 0), "right_point");
         else
            step(0, 0, 0, 0, 1, o(0, 0, 0, 7, 0, 1, 0), "right_match");
         if (k < 7) begin
            serve(0, k);
            countdown(0, k);
         end
      end
      step(1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0), "reset_from_over");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
